// File: rtl/mux_2x1_df.sv
// 2:1 dataflow mux with a registered, parity-tagged copy and a saturating select-change counter.
// Define MUX_2X1_DF_SEL_SYNC_EN to pass select through a 2-flop synchronizer first.
module mux_2x1_df #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             select,
  input  logic             en,
  output logic [WIDTH-1:0] mux_out,
  output logic [WIDTH-1:0] mux_out_q,
  output logic             out_parity,
  output logic [CNT_W-1:0] sel_changes
);

  logic             sel_eff;
  logic [WIDTH-1:0] data_d, data_q;
  logic             parity_d, parity_q;
  logic             sel_prev_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;

`ifdef MUX_2X1_DF_SEL_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], select};
    end
  end

  assign sel_eff = sync_q[1];
`else
  assign sel_eff = select;
`endif

  // Ternary keeps the A==B bitwise merge when sel_eff is X in simulation.
  assign mux_out = sel_eff ? A : B;

  always_comb begin
    data_d   = data_q;
    parity_d = parity_q;
    if (en) begin
      data_d   = mux_out;
      parity_d = ^mux_out;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if ((sel_eff != sel_prev_q) && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q     <= '0;
      parity_q   <= 1'b0;
      sel_prev_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      data_q     <= data_d;
      parity_q   <= parity_d;
      sel_prev_q <= sel_eff;
      cnt_q      <= cnt_d;
    end
  end

  assign mux_out_q   = data_q;
  assign out_parity  = parity_q;
  assign sel_changes = cnt_q;

endmodule

// File: tb/tb_mux_2x1_df.sv
// Directed bench for mux_2x1_df: stimulus queues expected values, a monitor pops and compares.
module tb_mux_2x1_df;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] a, b;
  logic       select, en;

  logic [7:0] mux_out, mux_out_q, sel_changes;
  logic       out_parity;
  logic       s_mux_out, s_mux_out_q, s_parity;
  logic [1:0] s_sel_changes;

  always #5 clk = ~clk;

  mux_2x1_df #(.WIDTH(8), .CNT_W(8)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .A          (a),
    .B          (b),
    .select     (select),
    .en         (en),
    .mux_out    (mux_out),
    .mux_out_q  (mux_out_q),
    .out_parity (out_parity),
    .sel_changes(sel_changes)
  );

  mux_2x1_df #(.WIDTH(1), .CNT_W(2)) u_sat (
    .clk        (clk),
    .rst_n      (rst_n),
    .A          (a[0]),
    .B          (b[0]),
    .select     (select),
    .en         (en),
    .mux_out    (s_mux_out),
    .mux_out_q  (s_mux_out_q),
    .out_parity (s_parity),
    .sel_changes(s_sel_changes)
  );

  typedef enum int {KMux, KQ, KPar, KCnt, KSMux, KSCnt} kind_e;
  typedef struct {
    string      name;
    kind_e      kind;
    logic [7:0] exp;
  } sb_t;

  sb_t  sb_q[$];
  event smp_ev;
  int   n_chk  = 0;
  int   n_fail = 0;

  // Monitor: drains every queued expectation against the outputs presented now.
  initial begin
    sb_t        e;
    logic [7:0] act;
    forever begin
      @(smp_ev);
      while (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        case (e.kind)
          KMux:    act = mux_out;
          KQ:      act = mux_out_q;
          KPar:    act = {7'd0, out_parity};
          KCnt:    act = sel_changes;
          KSMux:   act = {7'd0, s_mux_out};
          default: act = {6'd0, s_sel_changes};
        endcase
        n_chk++;
        if (act !== e.exp) begin
          n_fail++;
          $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
        end
      end
    end
  end

  task automatic exp_val(input string name, input kind_e kind, input logic [7:0] exp);
    sb_t e;
    e.name = name;
    e.kind = kind;
    e.exp  = exp;
    sb_q.push_back(e);
  endtask

  task automatic sample();
    -> smp_ev;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; a = 8'h00; b = 8'h00; select = 1'b0; en = 1'b0;
    #3;
    exp_val("rst_q", KQ, 8'h00);
    exp_val("rst_par", KPar, 8'h00);
    exp_val("rst_cnt", KCnt, 8'h00);
    exp_val("rst_scnt", KSCnt, 8'h00);
    sample();
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Combinational selection, no clock edge in between.
    select = 1'b1; a = 8'h00; b = 8'h01; #1;
    exp_val("sel1_a0", KMux, 8'h00); exp_val("w1_sel1_a0", KSMux, 8'h00); sample();
    a = 8'h01; b = 8'h00; #1;
    exp_val("sel1_a1", KMux, 8'h01); exp_val("w1_sel1_a1", KSMux, 8'h01); sample();
    select = 1'b0; #1;
    exp_val("sel0_b0", KMux, 8'h00); exp_val("w1_sel0_b0", KSMux, 8'h00); sample();
    a = 8'h00; b = 8'h01; #1;
    exp_val("sel0_b1", KMux, 8'h01); exp_val("w1_sel0_b1", KSMux, 8'h01); sample();
    tick();

    // Registered path and enable hold.
    en = 1'b1; b = 8'hA5;
    tick();
    exp_val("load_a5", KQ, 8'hA5); exp_val("par_a5", KPar, 8'h00); sample();
    en = 1'b0; b = 8'h01;
    tick();
    exp_val("hold_a5", KQ, 8'hA5); exp_val("mux_01", KMux, 8'h01); sample();
    en = 1'b1; b = 8'h07;
    tick();
    exp_val("load_07", KQ, 8'h07); exp_val("par_07", KPar, 8'h01); sample();
    en = 1'b0;
    exp_val("cnt_idle", KCnt, 8'h00); sample();

    // Five select toggles, with en low.
    for (int i = 0; i < 5; i++) begin
      select = ~select;
      tick();
    end
    exp_val("cnt_5", KCnt, 8'h05); exp_val("scnt_sat", KSCnt, 8'h03);
    exp_val("q_hold_toggle", KQ, 8'h07); sample();
    a = 8'h5A; b = 8'h11;
    tick();
    exp_val("cnt_ab_only", KCnt, 8'h05); exp_val("mux_5a", KMux, 8'h5A);
    exp_val("scnt_stays", KSCnt, 8'h03); sample();

    // Asynchronous reset mid-cycle.
    en = 1'b1; a = 8'hFF;
    tick();
    exp_val("load_ff", KQ, 8'hFF); sample();
    #1 rst_n = 1'b0; #1;
    exp_val("arst_q", KQ, 8'h00); exp_val("arst_par", KPar, 8'h00);
    exp_val("arst_cnt", KCnt, 8'h00); exp_val("arst_scnt", KSCnt, 8'h00);
    exp_val("arst_mux", KMux, 8'hFF); sample();
    select = 1'b0; b = 8'h3C; #1;
    exp_val("arst_mux_b", KMux, 8'h3C); sample();
    tick();
    exp_val("rst_held_q", KQ, 8'h00); exp_val("rst_held_cnt", KCnt, 8'h00); sample();

    // First edge after release counts select=1 against sel_prev=0.
    select = 1'b1; en = 1'b0; a = 8'hFF; rst_n = 1'b1;
    tick();
    exp_val("post_rst_cnt", KCnt, 8'h01); exp_val("post_rst_scnt", KSCnt, 8'h01);
    exp_val("post_rst_q", KQ, 8'h00); sample();
    en = 1'b1;
    tick();
    exp_val("post_rst_load", KQ, 8'hFF); exp_val("post_rst_par", KPar, 8'h00);
    exp_val("post_rst_cnt2", KCnt, 8'h01); sample();

    #2;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_2x1_df.md
MUX_2X1_DF -- requirements
Module: mux_2x1_df

Interface
REQ-001 Parameter WIDTH, default 1, data width of A, B, mux_out and mux_out_q.
REQ-002 Parameter CNT_W, default 8, width of the select-change counter.
REQ-003 Port clk, input, 1, single clock; all flops rise-edge triggered.
REQ-004 Port rst_n, input, 1, asynchronous active-low reset.
REQ-005 Port mux_out, output, WIDTH, combinational mux result.
REQ-006 Port A, input, WIDTH, data input chosen when select=1.
REQ-007 Port B, input, WIDTH, data input chosen when select=0.
REQ-008 Port select, input, 1, channel select.
REQ-009 Port en, input, 1, load enable for the registered output.
REQ-010 Port mux_out_q, output, WIDTH, registered mux result.
REQ-011 Port out_parity, output, 1, even-parity bit (XOR reduction) of mux_out_q.
REQ-012 Port sel_changes, output, CNT_W, saturating count of select transitions.

Function
REQ-013 mux_out SHALL equal A when the effective select is 1 and B when it is 0, with zero-cycle (dataflow) latency.
REQ-014 Effective select SHALL be the raw select input, except as modified under Configuration.
REQ-015 If the effective select is X or Z, mux_out SHALL be bitwise A where A==B and X elsewhere (simulation only).
REQ-016 On each rising clk edge with en=1, mux_out_q SHALL load mux_out (1-cycle latency).
REQ-017 With en=0, mux_out_q SHALL hold its value.
REQ-018 out_parity SHALL be registered together with mux_out_q, so it always matches the current mux_out_q.
REQ-019 The block SHALL keep a 1-bit register sel_prev holding the effective select sampled on the previous clk edge.
REQ-020 sel_changes SHALL increment by 1 on each clk edge where the effective select differs from sel_prev, independent of en.
REQ-021 sel_changes SHALL saturate at 2^CNT_W-1 and stay there until reset.
REQ-022 A and B changing with select constant SHALL NOT count as a transition.

Reset
REQ-023 While rst_n=0: mux_out_q=0, out_parity=0, sel_changes=0, sel_prev=0 and all synchronizer flops=0, applied asynchronously.
REQ-024 mux_out SHALL remain purely combinational and unaffected by reset.
REQ-025 Reset deassertion SHALL take effect from the first rising clk edge after rst_n goes high; a reset asserted mid-operation SHALL clear the state immediately.
REQ-026 After reset, the first clk edge SHALL count a transition if the effective select is 1, because sel_prev resets to 0.

Configuration
REQ-027 Macro MUX_2X1_DF_SEL_SYNC_EN defined: select passes through a 2-flop synchronizer (reset to 0). The effective select is the synchronizer output, so mux_out lags a select change by 2 clk edges and mux_out_q by 3.
REQ-028 Macro undefined: the effective select is the raw select, with no added latency.

Verification
REQ-029 WIDTH=1, macro off: select=1, A=0, B=1 -> mux_out=0. Then A=1, B=0 -> mux_out=1. Then select=0 -> mux_out=0. Then A=0, B=1 -> mux_out=1.
REQ-030 WIDTH=8, en=1: select=0, B=8'hA5 -> one clk later mux_out_q=8'hA5 and out_parity=0. Set en=0, then B=8'h01 -> mux_out_q stays 8'hA5.
REQ-031 Toggle select on each of 5 clk edges -> sel_changes=5. CNT_W=2 with 5 toggles -> sel_changes=3 (saturated).
REQ-032 Assert rst_n=0 between clock edges while mux_out_q=8'hFF and sel_changes=3 -> both read 0 immediately, while mux_out still tracks A/B/select.
REQ-033 Macro on: change select 0->1 -> mux_out changes after exactly 2 clk edges, mux_out_q after 3, and sel_changes increments once.
